// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-channel debounce and press pulses.
// Optional auto-repeat on masked buttons when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int unsigned       N_BTN           = 5,
    parameter int unsigned       DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned       CNT_W           = 17,
    parameter int unsigned       REPEAT_DELAY    = 50_000_000,
    parameter int unsigned       REPEAT_RATE     = 10_000_000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(5'b01001)
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] rise;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Counter only runs while the synchronised input disagrees with the level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = level_d & ~level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned      RptW        = 26;
    localparam logic [RptW-1:0]  RptDelayMax = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0]  RptRateMax  = RptW'(REPEAT_RATE - 1);

    logic [RptW-1:0]  rpt_cnt_q [N_BTN];
    logic [RptW-1:0]  rpt_cnt_d [N_BTN];
    logic [N_BTN-1:0] rpt_first_q, rpt_first_d;
    logic [N_BTN-1:0] rpt_fire;

    // rpt_first selects the initial delay until the first repeat has fired.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            rpt_cnt_d[i]   = '0;
            rpt_first_d[i] = 1'b0;
            rpt_fire[i]    = 1'b0;
            if (REPEAT_MASK[i] && level_q[i] && level_d[i]) begin
                if ((rpt_first_q[i] && rpt_cnt_q[i] == RptDelayMax) ||
                    (!rpt_first_q[i] && rpt_cnt_q[i] == RptRateMax)) begin
                    rpt_fire[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i]   = rpt_cnt_q[i] + 1'b1;
                    rpt_first_d[i] = rpt_first_q[i];
                end
            end else if (REPEAT_MASK[i] && rise[i]) begin
                rpt_first_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            rpt_first_q <= '0;
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= '0;
        end else begin
            rpt_first_q <= rpt_first_d;
            for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
        end
    end

    assign pulse_d = rise | rpt_fire;
`else
    logic unused_rpt_params;
    assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_MASK};
    assign pulse_d = rise;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=8, repeat 40/10).
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] raw = '0;
    logic [4:0] level;
    logic [4:0] pulse;

    int n_cmp = 0;
    int n_err = 0;
    int pcnt[5];

`ifdef BTN_AUTOREPEAT_EN
    localparam bit Ar = 1'b1;
`else
    localparam bit Ar = 1'b0;
`endif

    btn_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .REPEAT_DELAY   (40),
        .REPEAT_RATE    (10),
        .REPEAT_MASK    (5'b01001)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (rst),
        .btn_raw  (raw),
        .btn_level(level),
        .btn_pulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then sample outputs 1 ns later and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) if (pulse[i] === 1'b1) pcnt[i]++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 5; i++) pcnt[i] = 0;
    endtask

    initial begin
        logic [4:0] acc;
        clr_cnt();

        // 1: reset then idle
        rst = 1'b1;
        run(2);
        check_eq("rst_level", level, 0);
        check_eq("rst_pulse", pulse, 0);
        rst = 1'b0;
        acc = '0;
        repeat (50) begin
            tick();
            acc = acc | level | pulse;
        end
        check_eq("idle_quiet", acc, 0);

        // 2: press on U, level/pulse at t+10, release 10 cycles later without pulse
        clr_cnt();
        raw[0] = 1'b1;
        run(9);
        check_eq("u_pre_level", level, 0);
        run(1);
        check_eq("u_level", level, 5'h01);
        check_eq("u_pulse", pulse, 5'h01);
        run(1);
        check_eq("u_pulse_end", pulse, 0);
        run(19);
        raw[0] = 1'b0;
        run(9);
        check_eq("u_rel_pre", level, 5'h01);
        run(1);
        check_eq("u_rel_level", level, 0);
        check_eq("u_rel_pulse", pulse, 0);
        check_eq("u_pcnt", pcnt[0], 1);

        // glitch boundary: 7-cycle high never qualifies, 8-cycle high does
        clr_cnt();
        raw[2] = 1'b1;
        run(7);
        raw[2] = 1'b0;
        run(12);
        check_eq("r7_level", level, 0);
        check_eq("r7_pcnt", pcnt[2], 0);
        raw[2] = 1'b1;
        run(8);
        raw[2] = 1'b0;
        run(2);
        check_eq("r8_level", level, 5'h04);
        check_eq("r8_pulse", pulse, 5'h04);
        run(8);
        check_eq("r8_rel", level, 0);
        check_eq("r8_pcnt", pcnt[2], 1);

        // 3: bounce on C
        clr_cnt();
        raw[4] = 1'b1; run(3);
        raw[4] = 1'b0; run(2);
        raw[4] = 1'b1; run(5);
        raw[4] = 1'b0; run(1);
        raw[4] = 1'b1;
        run(9);
        check_eq("c_bounce_level", level, 0);
        check_eq("c_bounce_pcnt", pcnt[4], 0);
        run(1);
        check_eq("c_pulse", pulse, 5'h10);
        run(5);
        check_eq("c_pcnt", pcnt[4], 1);
        raw[4] = 1'b0;
        run(12);

        // 4: L and R simultaneously
        clr_cnt();
        raw[2:1] = 2'b11;
        run(10);
        check_eq("lr_pulse", pulse, 5'h06);
        run(1);
        check_eq("lr_pulse_end", pulse, 0);
        check_eq("lr_level", level, 5'h06);
        raw[2:1] = 2'b00;
        run(12);
        check_eq("lr_pcnt", pcnt[1] + pcnt[2], 2);

        // 5: D held, reset mid-hold, re-press after reset
        clr_cnt();
        raw[3] = 1'b1;
        run(10);
        check_eq("d_pulse", pulse, 5'h08);
        run(4);
        rst = 1'b1;
        run(1);
        check_eq("d_rst_level", level, 0);
        check_eq("d_rst_pulse", pulse, 0);
        rst = 1'b0;
        run(9);
        check_eq("d_re_pre", level, 0);
        run(1);
        check_eq("d_re_pulse", pulse, 5'h08);
        raw[3] = 1'b0;
        run(12);

        // reset on the very edge a pulse would fire suppresses it
        clr_cnt();
        raw[0] = 1'b1;
        run(9);
        rst = 1'b1;
        run(1);
        check_eq("rstwin_pulse", pulse, 0);
        check_eq("rstwin_level", level, 0);
        raw[0] = 1'b0;
        rst = 1'b0;
        run(12);
        check_eq("rstwin_pcnt", pcnt[0], 0);

        // 6: U and L held 80 cycles; only U repeats when enabled
        clr_cnt();
        raw[1:0] = 2'b11;
        run(10);
        check_eq("ar_press", pulse, 5'h03);
        run(39);
        check_eq("ar_pre_rpt", pulse, 0);
        run(1);
        check_eq("ar_first_rpt", pulse, Ar ? 5'h01 : 5'h00);
        run(30);
        raw[1:0] = 2'b00;
        run(20);
        check_eq("ar_u_pcnt", pcnt[0], Ar ? 5 : 1);
        check_eq("ar_l_pcnt", pcnt[1], 1);
        check_eq("ar_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
